// File: rtl/riscv_dmem_resp.sv
// Purpose: handshaked data-memory responder (byte-enabled write / full-word read on a word array).
// Latency: response valid WAIT_CYC+1 cycles after the request accept edge; one request outstanding.
// Backpressure: response held stable until i_rsp_ready; requests are refused until the response is taken.
module riscv_dmem_resp #(
    parameter int XLEN     = 32,
    parameter int ADDR_BIT = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [ADDR_BIT-1:0] i_req_addr,
    input  logic [XLEN-1:0]     i_req_wdata,
    input  logic [3:0]          i_req_byte_sel,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [XLEN-1:0]     o_rsp_rdata,
    output logic                o_rsp_err
);

    localparam int DEPTH = 1 << (ADDR_BIT - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_accept;
    logic                  w_access;
    logic                  w_rsp_done;

    logic                  r_we;
    logic [ADDR_BIT-3:0]   r_idx;
    logic [XLEN-1:0]       r_wdata;
    logic [3:0]            r_bsel;
    logic [XLEN-1:0]       r_rdata;
    logic                  r_err;
    logic [XLEN-1:0]       r_mem [DEPTH];

    logic                  w_bsel_none;
    logic                  w_unused_addr;

    // Byte offset within the word is irrelevant: accesses are always word-wide.
    assign w_unused_addr = ^i_req_addr[1:0];

    assign w_bsel_none = (r_bsel == 4'b0000);

    // Ready only in IDLE, and forced low while reset is asserted.
    assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

    // FSM state and wait counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP until taken.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid && o_req_ready) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = 4'(WAIT_CYC);
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the request so the requester may change its inputs after the accept edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_bsel  <= 4'b0000;
        end else if (w_accept) begin
            r_we    <= i_req_we;
            r_idx   <= i_req_addr[ADDR_BIT-1:2];
            r_wdata <= i_req_wdata;
            r_bsel  <= i_req_byte_sel;
        end
    end

    // Array write: only enabled lanes change; never written while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (w_access && r_we && !w_bsel_none && !i_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (r_bsel[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response registers: loaded at the access edge, cleared when the response is taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_rdata <= (!r_we && !w_bsel_none) ? r_mem[r_idx] : '0;
            r_err   <= w_bsel_none;
        end else if (w_rsp_done) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Bench for riscv_dmem_resp: two instances (WAIT_CYC=2 and WAIT_CYC=0),
// a directed vector table, hand-written reset/backpressure sequences and
// randomized traffic checked against a word-array reference model.
module tb_riscv_dmem_resp;

    logic        clk;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        we        [2];
    logic [11:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [3:0]  bsel      [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rdata     [2];
    logic        err       [2];

    int n_checks = 0;
    int n_fail   = 0;

    riscv_dmem_resp #(.XLEN(32), .ADDR_BIT(12), .WAIT_CYC(2)) u_dut_w2 (
        .i_clk(clk), .i_rst(rst[0]),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_we(we[0]), .i_req_addr(addr[0]), .i_req_wdata(wdata[0]),
        .i_req_byte_sel(bsel[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_rdata(rdata[0]), .o_rsp_err(err[0])
    );

    riscv_dmem_resp #(.XLEN(32), .ADDR_BIT(12), .WAIT_CYC(0)) u_dut_w0 (
        .i_clk(clk), .i_rst(rst[1]),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_we(we[1]), .i_req_addr(addr[1]), .i_req_wdata(wdata[1]),
        .i_req_byte_sel(bsel[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_rdata(rdata[1]), .o_rsp_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // One complete transaction; hold = cycles the response is backpressured.
    task automatic txn(input int d, input logic w, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] bs, input int hold,
                       input logic [31:0] exp_rd, input logic exp_err);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        we[d]        = w;
        addr[d]      = a;
        wdata[d]     = wd;
        bsel[d]      = bs;
        rsp_ready[d] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        we[d]        = 1'($urandom());
        addr[d]      = 12'($urandom());
        wdata[d]     = $urandom();
        bsel[d]      = 4'($urandom());
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 32'(n), 32'(wc(d) + 1));
        chk("rsp_rdata", rdata[d], exp_rd);
        chk("rsp_err", 32'(err[d]), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1'b1;
            @(negedge clk);
            chk("bp_valid_held", 32'(rsp_valid[d]), 32'd1);
            chk("bp_rdata_stable", rdata[d], exp_rd);
            chk("bp_err_stable", 32'(err[d]), 32'(exp_err));
            chk("bp_req_ready_low", 32'(req_ready[d]), 32'd0);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        chk("post_rsp_valid_low", 32'(rsp_valid[d]), 32'd0);
        chk("post_rsp_rdata_zero", rdata[d], 32'd0);
        chk("post_rsp_err_zero", 32'(err[d]), 32'd0);
        chk("post_rsp_req_ready", 32'(req_ready[d]), 32'd1);
        rsp_ready[d] = 1'b0;
    endtask

    typedef struct {
        int          d;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bsel;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[15];

    // Reference model: one word per (instance, word index); lanes merged by byte enables.
    logic [31:0] mdl [int];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] bs);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (bs[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    initial begin
        int           seen;
        int           key;
        logic [11:0]  ra;
        logic [31:0]  rwd;
        logic [3:0]   rbs;
        logic         rwe;
        logic [31:0]  erd;

        vt[0]  = '{0, 1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        vt[1]  = '{0, 1'b0, 12'h010, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{0, 1'b1, 12'h010, 32'h0000AA00, 4'b0010, 32'h0,        1'b0};
        vt[3]  = '{0, 1'b0, 12'h010, 32'h0,        4'b1111, 32'hDEADAAEF, 1'b0};
        vt[4]  = '{0, 1'b1, 12'h010, 32'h12340000, 4'b1100, 32'h0,        1'b0};
        vt[5]  = '{0, 1'b0, 12'h010, 32'h0,        4'b1111, 32'h1234AAEF, 1'b0};
        vt[6]  = '{0, 1'b0, 12'h010, 32'h0,        4'b0000, 32'h0,        1'b1};
        vt[7]  = '{0, 1'b1, 12'h010, 32'hFFFFFFFF, 4'b0000, 32'h0,        1'b1};
        vt[8]  = '{0, 1'b0, 12'h010, 32'h0,        4'b0001, 32'h1234AAEF, 1'b0};
        vt[9]  = '{0, 1'b0, 12'h013, 32'h0,        4'b1111, 32'h1234AAEF, 1'b0};
        vt[10] = '{1, 1'b1, 12'hFFC, 32'hCAFEF00D, 4'b1111, 32'h0,        1'b0};
        vt[11] = '{1, 1'b0, 12'hFFC, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0};
        vt[12] = '{1, 1'b0, 12'hFFF, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0};
        vt[13] = '{1, 1'b1, 12'hFFF, 32'h00000055, 4'b0001, 32'h0,        1'b0};
        vt[14] = '{1, 1'b0, 12'hFFC, 32'h0,        4'b1000, 32'hCAFEF055, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; we[d] = 1'b0; addr[d] = '0;
            wdata[d] = '0; bsel[d] = '0; rsp_ready[d] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge clk);
        chk("rel_req_ready_w2", 32'(req_ready[0]), 32'd1);
        chk("rel_req_ready_w0", 32'(req_ready[1]), 32'd1);

        // Directed vectors
        for (int i = 0; i < 15; i++)
            txn(vt[i].d, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].bsel, 0,
                vt[i].exp_rd, vt[i].exp_err);

        // Backpressure: response held 5 cycles, stray requests ignored
        txn(0, 1'b0, 12'h010, 32'h0, 4'b1111, 5, 32'h1234AAEF, 1'b0);
        txn(0, 1'b0, 12'h010, 32'h0, 4'b1111, 0, 32'h1234AAEF, 1'b0);

        // Reset in the middle of a write's wait phase
        txn(0, 1'b1, 12'h020, 32'h0, 4'b1111, 0, 32'h0, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h020;
        wdata[0] = 32'h11111111; bsel[0] = 4'b1111; rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("pre_abort_req_ready", 32'(req_ready[0]), 32'd0);
        rst[0] = 1'b1;
        #1;
        chk("abort_req_ready", 32'(req_ready[0]), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("abort_rdata", rdata[0], 32'd0);
        chk("abort_err", 32'(err[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[0]) seen++;
        end
        chk("abort_no_response", 32'(seen), 32'd0);
        rsp_ready[0] = 1'b0;
        txn(0, 1'b0, 12'h020, 32'h0, 4'b1111, 0, 32'h0, 1'b0);

        // Randomized traffic against the reference model
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++) begin
                rwd = $urandom();
                txn(d, 1'b1, 12'(12'h100 + 4 * w), rwd, 4'b1111, 0, 32'h0, 1'b0);
                mdl[d * 4096 + 64 + w] = rwd;
            end
            for (int t = 0; t < 60; t++) begin
                ra  = 12'(12'h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
                key = d * 4096 + int'(ra[11:2]);
                rwe = 1'($urandom());
                rwd = $urandom();
                rbs = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom());
                erd = (!rwe && rbs != 4'b0000) ? mdl[key] : 32'h0;
                txn(d, rwe, ra, rwd, rbs, $urandom_range(0, 3), erd, rbs == 4'b0000);
                if (rwe && rbs != 4'b0000)
                    mdl[key] = merge(mdl[key], rwd, rbs);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
